regfile_mp_seqclr: RTL and testbench

//  Parametrised multi-read-port register file for the RV32 datapath. It keeps NREGS x XLEN

---
 rtl/regfile_mp_seqclr.sv | 149 ++++++++++++++
 tb/tb_regfile_mp_seqclr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_seqclr.sv
// Multi-read-port register file with write->read bypass and a one-entry-per-cycle clear
// engine that runs after reset and on every flush request.
module regfile_mp_seqclr #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [AW-1:0]     wb_addr
);

  localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_L  = (AW + 1)'(NREGS);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t              state_r, state_n;
  logic [PW-1:0]       ptr_r, ptr_n;
  logic                busy_r;
  logic [XLEN-1:0]     mem_r [NREGS];
  logic                wr_ok_s, arr_we_s, clr_wr_s;
  logic [XLEN-1:0]     rd_val_s [NRD];
  logic [NRD*XLEN-1:0] rd_data_r;
  logic [NRD-1:0]      rd_valid_r;
  logic [XLEN-1:0]     wb_data_r;
  logic [AW-1:0]       wb_addr_r;

  // A flush arriving together with a write wins; out-of-range writes are dropped entirely.
  assign wr_ok_s  = (state_r == ST_IDLE) && !clr && we && ({1'b0, waddr} < NREGS_L);
  assign arr_we_s = wr_ok_s && !((ZERO_REG != 0) && (waddr == {AW{1'b0}}));
  assign clr_wr_s = (state_r == ST_CLEAR) && !clr && !rst;

  // Clear engine next-state and pointer
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (clr) begin
          state_n = ST_CLEAR;
          ptr_n   = {PW{1'b0}};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          ptr_n = {PW{1'b0}};
        end else if (ptr_r == LAST_PTR) begin
          state_n = ST_IDLE;
          ptr_n   = {PW{1'b0}};
        end else begin
          ptr_n = ptr_r + PW'(1);
        end
      end
      default: begin
        state_n = ST_CLEAR;
        ptr_n   = {PW{1'b0}};
      end
    endcase
  end

  // Clear engine state register; busy tracks the registered state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {PW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      busy_r  <= (state_n == ST_CLEAR);
    end
  end

  // Storage array: the clear engine owns the write port while active
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      mem_r[ptr_r] <= {XLEN{1'b0}};
    end else if (arr_we_s) begin
      mem_r[waddr[PW-1:0]] <= wdata;
    end
  end

  // Per-port read value with zero-register, range and write-first bypass handling
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val_s[p] = {XLEN{1'b0}};
      if ((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == {AW{1'b0}})) begin
        rd_val_s[p] = {XLEN{1'b0}};
      end else if (!({1'b0, rd_addr[p*AW +: AW]} < NREGS_L)) begin
        rd_val_s[p] = {XLEN{1'b0}};
      end else if (wr_ok_s && (waddr == rd_addr[p*AW +: AW])) begin
        rd_val_s[p] = wdata;
      end else begin
        rd_val_s[p] = mem_r[rd_addr[p*AW +: PW]];
      end
    end
  end

  // Registered read ports; data holds when a port is not read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {(NRD*XLEN){1'b0}};
      rd_valid_r <= {NRD{1'b0}};
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if ((state_r == ST_IDLE) && rd_en[p]) begin
          rd_valid_r[p]              <= 1'b1;
          rd_data_r[p*XLEN +: XLEN]  <= rd_val_s[p];
        end else begin
          rd_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  // Writeback echo of the last accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_r <= {XLEN{1'b0}};
      wb_addr_r <= {AW{1'b0}};
    end else if (wr_ok_s) begin
      wb_data_r <= wdata;
      wb_addr_r <= waddr;
    end
  end

  assign busy     = busy_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign wb_data  = wb_data_r;
  assign wb_addr  = wb_addr_r;

endmodule

// File: tb/tb_regfile_mp_seqclr.sv
// Directed self-checking bench for regfile_mp_seqclr (default parameters).
module tb_regfile_mp_seqclr;

  logic        clk = 1'b0;
  logic        rst, clr, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_seqclr dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wb_data(wb_data), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    clr = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; rd_en = 2'b00; rd_addr = 10'd0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({rd_valid, rd_data, wb_data, wb_addr, busy} !== {2'b00, 64'd0, 32'd0, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b data=%h wb=%h/%0d busy=%b want 00/0/0/0/1",
               rd_valid, rd_data, wb_data, wb_addr, busy);
    end
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_err++;
      $display("FAIL reset_busy_len: got %0d cycles want 32", cnt);
    end
    for (int i = 0; i < 32; i += 2) begin
      rd_en = 2'b11; rd_addr = {5'(i + 1), 5'(i)};
      @(negedge clk);
      n_cmp++;
      if ({rd_valid, rd_data} !== {2'b11, 64'd0}) begin
        n_err++;
        $display("FAIL reset_zero r%0d/r%0d: got valid=%b data=%h want 11/0", i, i + 1, rd_valid, rd_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    @(negedge clk);
    we = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    n_cmp++;
    if ({wb_data, wb_addr} !== {32'hDEADBEEF, 5'd5}) begin
      n_err++;
      $display("FAIL wb_echo: got %h/%0d want deadbeef/5", wb_data, wb_addr);
    end
    @(negedge clk);
    rd_en = 2'b00;
    n_cmp++;
    if ({rd_valid, rd_data[31:0]} !== {2'b01, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL read_r5: got valid=%b data=%h want 01/deadbeef", rd_valid, rd_data[31:0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_valid, rd_data[31:0]} !== {2'b00, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL read_hold: got valid=%b data=%h want 00/deadbeef", rd_valid, rd_data[31:0]);
    end
  endtask

  task automatic test_ports();
    we = 1'b1; waddr = 5'd10; wdata = 32'h0A0A0A0A;
    @(negedge clk);
    waddr = 5'd11; wdata = 32'h0B0B0B0B;
    @(negedge clk);
    we = 1'b0; rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
    @(negedge clk);
    rd_en = 2'b00;
    n_cmp++;
    if ({rd_valid, rd_data} !== {2'b11, 32'h0B0B0B0B, 32'h0A0A0A0A}) begin
      n_err++;
      $display("FAIL independent_ports: got valid=%b data=%h want 11/0b0b0b0b0a0a0a0a", rd_valid, rd_data);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if ({rd_valid, rd_data} !== {2'b11, 32'h12345678, 32'h12345678}) begin
      n_err++;
      $display("FAIL bypass: got valid=%b data=%h want 11/1234567812345678", rd_valid, rd_data);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    we = 1'b0; rd_en = 2'b01; rd_addr = 10'd0;
    n_cmp++;
    if ({wb_data, wb_addr} !== {32'hFFFFFFFF, 5'd0}) begin
      n_err++;
      $display("FAIL zero_wb: got %h/%0d want ffffffff/0", wb_data, wb_addr);
    end
    @(negedge clk);
    rd_en = 2'b00;
    n_cmp++;
    if ({rd_valid[0], rd_data[31:0]} !== {1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL zero_read: got valid=%b data=%h want 1/0", rd_valid[0], rd_data[31:0]);
    end
  endtask

  task automatic test_clr_drop();
    int cnt;
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
    @(negedge clk);
    idle_inputs();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      cnt++;
      if (cnt == 11) begin
        idle_inputs();
        n_cmp++;
        if ({rd_valid, wb_data, wb_addr} !== {2'b00, 32'hA5A5A5A5, 5'd3}) begin
          n_err++;
          $display("FAIL busy_ignore: got valid=%b wb=%h/%0d want 00/a5a5a5a5/3", rd_valid, wb_data, wb_addr);
        end
      end
      if (cnt == 10) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111; rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
      end
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_err++;
      $display("FAIL clr_busy_len: got %0d cycles want 32", cnt);
    end
    rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
    @(negedge clk);
    rd_en = 2'b00;
    n_cmp++;
    if ({rd_valid, rd_data} !== {2'b11, 64'd0}) begin
      n_err++;
      $display("FAIL clr_result: got valid=%b data=%h want 11/0", rd_valid, rd_data);
    end
  endtask

  task automatic test_restart();
    int cnt;
    int early;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) early++;
      if (c < 19) @(negedge clk);
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL restart_pre: got %0d idle samples want 0", early);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_err++;
      $display("FAIL restart_busy_len: got %0d cycles want 32", cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_ports();
    test_bypass();
    test_zero_reg();
    test_clr_drop();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
